fp_add_arbiter: RTL and testbench
=================================

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter LATENCY, default 4, fixed cycles from pipe_valid to matching pipe_res_valid of the shared FP add pipeline.
REQ-002 Parameter DEPTH, default 4 (power of two, >=2), per-requester result FIFO depth and credit limit.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in0_valid/in1_valid  in  1  requester i offers operand pair.
REQ-006 in0_a, in0_b, in1_a, in1_b  in  32  IEEE-754 single operands.
REQ-007 in0_ready/in1_ready  out  1  requester i pair accepted this cycle when valid&ready.
REQ-008 pipe_valid  out  1  issue strobe to shared adder pipeline.
REQ-009 pipe_a, pipe_b  out  32  operands to pipeline, muxed from granted requester.
REQ-010 pipe_res_valid  in  1  pipeline result strobe; pipe_res  in  32  pipeline result.
REQ-011 out0_valid/out1_valid  out  1  result available to requester i.
REQ-012 out0_data/out1_data  out  32  result for requester i (FIFO head).
REQ-013 out0_ready/out1_ready  in  1  requester i consumes result when valid&ready.
REQ-014 busy  out  1  any issued operation not yet popped by its requester.
REQ-015 err  out  1  sticky: pipe_res_valid disagrees with internal issue tracking.

Function
REQ-016 Eligibility: requester i eligible when in_i_valid=1 and credit_i>0.
REQ-017 Arbitration: round-robin pointer ptr; single eligible requester wins; both eligible -> requester ptr wins.
REQ-018 in_i_ready = 1 only for the winner; combinational from valids, credits, ptr; at most one ready per cycle.
REQ-019 Issue: on winner transfer, pipe_valid=1, pipe_a/pipe_b = winner operands, same cycle (zero-latency issue); no grant -> pipe_valid=0, pipe_a/pipe_b=0.
REQ-020 ptr update: after grant to i, ptr <= other requester; no grant -> ptr unchanged.
REQ-021 Tag tracking: LATENCY-stage shift register of {valid, tag}; stage 0 loaded with {pipe_valid, winner id} every cycle.
REQ-022 Result routing: when pipe_res_valid=1, pipe_res pushed into FIFO selected by tag at tracker output stage.
REQ-023 Credits: credit_i reset to DEPTH; -1 on issue from i; +1 on pop of out_i; both same cycle -> unchanged; range 0..DEPTH, never wraps.
REQ-024 Credit scheme guarantees FIFO push never occurs when full; push to full FIFO still sets err and drops data.
REQ-025 FIFOs first-word-fall-through: out_i_valid = FIFO i non-empty, out_i_data = head; push and pop same cycle on non-empty FIFO both take effect.
REQ-026 Push into empty FIFO visible at out_i_valid the following cycle.
REQ-027 err set when pipe_res_valid != tracker output valid bit; cleared only by rst.
REQ-028 busy = (credit0 != DEPTH) or (credit1 != DEPTH).
REQ-029 Minimum issue-to-out latency LATENCY+1 cycles; sustained throughput one issue per cycle while credits allow.

Reset
REQ-030 rst asserted: ptr=0, credits=DEPTH, FIFOs empty, tracker cleared, err=0, busy=0, all valids/readys=0, data outputs=0.
REQ-031 rst mid-operation discards in-flight tags and buffered results; results arriving after rst deassertion with no tracked issue set err.

Structure
REQ-032 Shared package fp_pkg holds FP_WIDTH=32, requester id type (1 bit), default LATENCY and DEPTH.
REQ-033 One sub-module fp_resp_fifo (parameter DEPTH, 32-bit FWFT sync FIFO, async active-high reset), instantiated twice.

Verification (bench models pipeline as LATENCY-deep delay of a+b)
REQ-034 in0 issues 0x3F800000+0x40000000, out0_ready=1 -> out0_data=0x40400000 at cycle LATENCY+1, credit0 restored, busy=0 next cycle.
REQ-035 Both valid every cycle, outputs always ready -> grants alternate 0,1,0,1 starting with 0; pipe_valid=1 every cycle; each result on its own port.
REQ-036 out1_ready=0, in1 valid continuously -> exactly DEPTH=4 issues, then in1_ready=0; in0 still served; one pop on out1 -> one further in1 issue.
REQ-037 Same-cycle pop and grant on requester 0 with credit0=0 before cycle -> grant blocked that cycle, issued next cycle.
REQ-038 Inject pipe_res_valid with empty tracker -> err=1 and held until rst.
REQ-039 rst asserted with 3 operations in flight -> all outputs at reset values, FIFOs empty, credits=DEPTH after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and defaults for the FP add arbiter slice.
package fp_pkg;

    localparam int unsigned FP_WIDTH    = 32;
    localparam int unsigned DEF_LATENCY = 4;
    localparam int unsigned DEF_DEPTH   = 4;

    typedef logic req_id_t;
    typedef logic [FP_WIDTH-1:0] fp_word_t;

    // One tracker stage: whether an issue happened and who issued it
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/fp_resp_fifo.sv
// First-word-fall-through result FIFO; head is zero while empty.
module fp_resp_fifo
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  fp_word_t push_data,
    input  logic     pop,
    output logic     valid,
    output fp_word_t head,
    output logic     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fp_word_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is masked until an entry is written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin, credit-throttled sharing of one fixed-latency FP add pipeline
// between two requesters, with tag tracking and per-requester result FIFOs.
module fp_add_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned DEPTH   = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in0_valid,
    input  logic [FP_WIDTH-1:0] in0_a,
    input  logic [FP_WIDTH-1:0] in0_b,
    output logic                in0_ready,
    input  logic                in1_valid,
    input  logic [FP_WIDTH-1:0] in1_a,
    input  logic [FP_WIDTH-1:0] in1_b,
    output logic                in1_ready,
    output logic                pipe_valid,
    output logic [FP_WIDTH-1:0] pipe_a,
    output logic [FP_WIDTH-1:0] pipe_b,
    input  logic                pipe_res_valid,
    input  logic [FP_WIDTH-1:0] pipe_res,
    output logic                out0_valid,
    output logic [FP_WIDTH-1:0] out0_data,
    input  logic                out0_ready,
    output logic                out1_valid,
    output logic [FP_WIDTH-1:0] out1_data,
    input  logic                out1_ready,
    output logic                busy,
    output logic                err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0] credit0;
    logic [CW-1:0] credit1;
    logic          ptr;
    logic          err_q;
    tag_t          trk [LATENCY];
    tag_t          trk_out;
    tag_t          issue_tag;
    logic          elig0, elig1;
    logic          grant0, grant1;
    logic          push0, push1;
    logic          pop0, pop1;
    logic          full0, full1;

    // Grant is suppressed during reset so no handshake leaks out
    assign elig0 = in0_valid && (credit0 != '0) && !rst;
    assign elig1 = in1_valid && (credit1 != '0) && !rst;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            grant0 = !ptr;
            grant1 = ptr;
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign in0_ready  = grant0;
    assign in1_ready  = grant1;
    assign pipe_valid = grant0 || grant1;
    assign pipe_a     = grant0 ? in0_a : (grant1 ? in1_a : '0);
    assign pipe_b     = grant0 ? in0_b : (grant1 ? in1_b : '0);

    always_comb begin
        issue_tag       = '0;
        issue_tag.valid = pipe_valid;
        issue_tag.id    = grant1;
    end

    // Tag shift register aligned with the pipeline's fixed latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) trk[i] <= '0;
        end else begin
            trk[0] <= issue_tag;
            for (int unsigned i = 1; i < LATENCY; i++) trk[i] <= trk[i-1];
        end
    end

    assign trk_out = trk[LATENCY-1];
    // Untracked results are only flagged, never buffered
    assign push0   = pipe_res_valid && trk_out.valid && (trk_out.id == 1'b0);
    assign push1   = pipe_res_valid && trk_out.valid && (trk_out.id == 1'b1);
    assign pop0    = out0_valid && out0_ready;
    assign pop1    = out1_valid && out1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit0 <= CW'(DEPTH);
            credit1 <= CW'(DEPTH);
            ptr     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (grant0 && !pop0 && credit0 != '0)                credit0 <= credit0 - 1'b1;
            else if (pop0 && !grant0 && credit0 != CW'(DEPTH))   credit0 <= credit0 + 1'b1;
            if (grant1 && !pop1 && credit1 != '0)                credit1 <= credit1 - 1'b1;
            else if (pop1 && !grant1 && credit1 != CW'(DEPTH))   credit1 <= credit1 + 1'b1;
            if (grant0)      ptr <= 1'b1;
            else if (grant1) ptr <= 1'b0;
            if ((pipe_res_valid != trk_out.valid) || (push0 && full0) || (push1 && full1))
                err_q <= 1'b1;
        end
    end

    assign busy = (credit0 != CW'(DEPTH)) || (credit1 != CW'(DEPTH));
    assign err  = err_q;

    fp_resp_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (pipe_res),
        .pop       (pop0),
        .valid     (out0_valid),
        .head      (out0_data),
        .full      (full0)
    );

    fp_resp_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (pipe_res),
        .pop       (pop1),
        .valid     (out1_valid),
        .head      (out1_data),
        .full      (full1)
    );

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: environment pipeline computes a+b after LATENCY
// cycles; a queue-based model predicts every handshake and result per cycle.
module tb_fp_add_arbiter;
    import fp_pkg::*;

    localparam int unsigned LAT = 4;
    localparam int unsigned DEP = 4;
    localparam int          NS  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in0_valid = 1'b0, in1_valid = 1'b0;
    logic [31:0] in0_a = '0, in0_b = '0, in1_a = '0, in1_b = '0;
    logic        in0_ready, in1_ready;
    logic        pipe_valid;
    logic [31:0] pipe_a, pipe_b;
    logic        pipe_res_valid = 1'b0;
    logic [31:0] pipe_res = '0;
    logic        out0_valid, out1_valid;
    logic [31:0] out0_data, out1_data;
    logic        out0_ready = 1'b1, out1_ready = 1'b1;
    logic        busy, err;

    always #5 clk = ~clk;

    fp_add_arbiter #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_a(in0_a), .in0_b(in0_b), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_a(in1_a), .in1_b(in1_b), .in1_ready(in1_ready),
        .pipe_valid(pipe_valid), .pipe_a(pipe_a), .pipe_b(pipe_b),
        .pipe_res_valid(pipe_res_valid), .pipe_res(pipe_res),
        .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
        .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
        .busy(busy), .err(err)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        sv [NS];
    logic [31:0] sd [NS];

    int          m_ptr;
    int          m_cred [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          fl_cyc [$];
    int          fl_id  [$];
    logic [31:0] fl_sum [$];
    logic        m_err;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] mk(input int n);
        return r2f(real'(n));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Compare all outputs against the model, then advance the model past this edge
    task automatic cyc_check();
        int          w;
        logic        e0, e1, pop0, pop1, res_exp, full0, full1;
        logic [31:0] ea, eb;
        @(negedge clk);
        if (rst) begin
            chk("rst_in0_ready", in0_ready, 0);   chk("rst_in1_ready", in1_ready, 0);
            chk("rst_pipe_valid", pipe_valid, 0); chk("rst_pipe_a", pipe_a, 0);
            chk("rst_pipe_b", pipe_b, 0);         chk("rst_out0_valid", out0_valid, 0);
            chk("rst_out1_valid", out1_valid, 0); chk("rst_out0_data", out0_data, 0);
            chk("rst_out1_data", out1_data, 0);   chk("rst_busy", busy, 0);
            chk("rst_err", err, 0);
            m_ptr = 0; m_cred[0] = DEP; m_cred[1] = DEP; m_err = 1'b0;
            q0.delete(); q1.delete(); fl_cyc.delete(); fl_id.delete(); fl_sum.delete();
            for (int i = 0; i < NS; i++) sv[i] = 1'b0;
            return;
        end
        e0 = in0_valid && (m_cred[0] > 0);
        e1 = in1_valid && (m_cred[1] > 0);
        w  = -1;
        if (e0 && e1) w = m_ptr;
        else if (e0)  w = 0;
        else if (e1)  w = 1;
        ea = (w == 0) ? in0_a : (w == 1) ? in1_a : 32'd0;
        eb = (w == 0) ? in0_b : (w == 1) ? in1_b : 32'd0;
        chk("in0_ready", in0_ready, (w == 0));
        chk("in1_ready", in1_ready, (w == 1));
        chk("pipe_valid", pipe_valid, (w >= 0));
        chk("pipe_a", pipe_a, ea);
        chk("pipe_b", pipe_b, eb);
        chk("out0_valid", out0_valid, (q0.size() > 0));
        chk("out1_valid", out1_valid, (q1.size() > 0));
        chk("out0_data", out0_data, (q0.size() > 0) ? q0[0] : 32'd0);
        chk("out1_data", out1_data, (q1.size() > 0) ? q1[0] : 32'd0);
        chk("busy", busy, (m_cred[0] != DEP) || (m_cred[1] != DEP));
        chk("err", err, m_err);
        // environment pipeline: result appears LAT cycles after issue
        if (pipe_valid) begin
            sv[(cyc + LAT) % NS] = 1'b1;
            sd[(cyc + LAT) % NS] = fadd(pipe_a, pipe_b);
        end
        pop0    = (q0.size() > 0) && out0_ready;
        pop1    = (q1.size() > 0) && out1_ready;
        full0   = (q0.size() == DEP);
        full1   = (q1.size() == DEP);
        res_exp = (fl_cyc.size() > 0) && (fl_cyc[0] == cyc);
        if (pipe_res_valid != res_exp) m_err = 1'b1;
        if (pop0) void'(q0.pop_front());
        if (pop1) void'(q1.pop_front());
        if (res_exp) begin
            if (pipe_res_valid) begin
                if (fl_id[0] == 0) begin
                    if (full0) m_err = 1'b1; else q0.push_back(fl_sum[0]);
                end else begin
                    if (full1) m_err = 1'b1; else q1.push_back(fl_sum[0]);
                end
            end
            void'(fl_cyc.pop_front()); void'(fl_id.pop_front()); void'(fl_sum.pop_front());
        end
        if (pop0) m_cred[0]++;
        if (pop1) m_cred[1]++;
        if (w >= 0) begin
            m_cred[w]--;
            fl_cyc.push_back(cyc + LAT);
            fl_id.push_back(w);
            fl_sum.push_back(fadd(ea, eb));
            m_ptr = 1 - w;
        end
    endtask

    task automatic next();
        int idx;
        @(posedge clk);
        #1;
        cyc++;
        idx = cyc % NS;
        pipe_res_valid = sv[idx];
        pipe_res       = sv[idx] ? sd[idx] : 32'd0;
        sv[idx]        = 1'b0;
    endtask

    task automatic step();
        cyc_check();
        next();
    endtask

    initial begin
        int n0, n1, seen;
        for (int i = 0; i < NS; i++) begin sv[i] = 1'b0; sd[i] = '0; end

        // reset state
        repeat (2) step();
        rst = 1'b0;
        step();

        // both requesters every cycle: strict alternation from requester 0
        in0_valid = 1'b1; in1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in0_a = mk(i + 1); in0_b = mk(100);
            in1_a = mk(i + 1); in1_b = mk(200);
            cyc_check();
            chk("alt_grant0", in0_ready, (i % 2 == 0));
            chk("alt_pipe_valid", pipe_valid, 1);
            next();
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        repeat (10) step();

        // single issue 1.0 + 2.0 -> 3.0 after LAT+1 cycles
        in0_valid = 1'b1; in0_a = 32'h3F80_0000; in0_b = 32'h4000_0000;
        cyc_check();
        chk("one_issue", in0_ready, 1);
        next();
        in0_valid = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            cyc_check();
            chk("one_early", out0_valid, 0);
            next();
        end
        cyc_check();
        chk("one_valid", out0_valid, 1);
        chk("one_data", out0_data, 32'h4040_0000);
        chk("one_busy_hold", busy, 1);
        next();
        cyc_check();
        chk("one_busy_clear", busy, 0);
        next();

        // requester 1 blocked on output: exactly DEP issues, requester 0 keeps going
        n0 = 0; n1 = 0;
        in0_valid = 1'b1; in1_valid = 1'b1; out0_ready = 1'b1; out1_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in0_a = mk(i + 20); in0_b = mk(300);
            in1_a = mk(i + 20); in1_b = mk(400);
            cyc_check();
            if (in0_ready) n0++;
            if (in1_ready) n1++;
            next();
        end
        chk("cred_in1_issues", 32'(n1), 32'd4);
        chk("cred_in0_served", 32'(n0 > 4), 32'd1);
        out1_ready = 1'b1;
        cyc_check();
        chk("cred_pop_valid", out1_valid, 1);
        chk("cred_blocked", in1_ready, 0);
        next();
        out1_ready = 1'b0; n1 = 0;
        for (int i = 0; i < 10; i++) begin
            cyc_check();
            if (in1_ready) n1++;
            next();
        end
        chk("cred_one_more", 32'(n1), 32'd1);
        in0_valid = 1'b0; in1_valid = 1'b0; out1_ready = 1'b1;
        repeat (20) step();
        chk("cred_drained", busy, 0);

        // credit0 = 0: same-cycle pop does not enable a grant until next cycle
        n0 = 0;
        in0_valid = 1'b1; out0_ready = 1'b0; in0_b = mk(500);
        for (int i = 0; i < 12; i++) begin
            in0_a = mk(i + 40);
            cyc_check();
            if (in0_ready) n0++;
            next();
        end
        chk("zc_issues", 32'(n0), 32'd4);
        out0_ready = 1'b1;
        cyc_check();
        chk("zc_pop_valid", out0_valid, 1);
        chk("zc_blocked", in0_ready, 0);
        next();
        out0_ready = 1'b0;
        cyc_check();
        chk("zc_granted", in0_ready, 1);
        next();
        cyc_check();
        chk("zc_blocked_again", in0_ready, 0);
        next();
        in0_valid = 1'b0; out0_ready = 1'b1;
        repeat (15) step();
        chk("zc_drained", busy, 0);

        // unexpected pipeline result sets sticky err
        cyc_check();
        chk("err_clean", err, 0);
        next();
        pipe_res_valid = 1'b1; pipe_res = 32'h1234_5678;
        step();
        for (int i = 0; i < 5; i++) begin
            cyc_check();
            chk("err_sticky", err, 1);
            chk("err_no_push", out0_valid | out1_valid, 0);
            next();
        end

        // reset with three operations in flight
        in0_valid = 1'b1; in1_valid = 1'b1; in0_a = mk(9); in1_a = mk(11);
        repeat (3) step();
        rst = 1'b1;
        cyc_check();
        chk("rr_pipe_valid", pipe_valid, 0);
        chk("rr_err", err, 0);
        next();
        step();
        rst = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
        repeat (10) step();
        cyc_check();
        chk("rr_busy", busy, 0);
        chk("rr_err_after", err, 0);
        chk("rr_fifo_empty", out0_valid | out1_valid, 0);
        next();
        // fresh traffic after reset: ptr back at 0, 7.0 + 8.0 = 15.0
        in0_valid = 1'b1; in0_a = mk(1); in0_b = mk(2);
        in1_valid = 1'b1; in1_a = mk(7); in1_b = mk(8);
        cyc_check();
        chk("rr_ptr_reset", in0_ready, 1);
        next();
        in0_valid = 1'b0;
        step();
        in1_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc_check();
            if (out1_valid) begin
                seen++;
                chk("rr_sum15", out1_data, 32'h4170_0000);
            end
            next();
        end
        chk("rr_sum_seen", 32'(seen), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
